// File: rtl/z16_register_file_if.sv
// Read/write bus between the Z16 decode/write-back stages and the register file.
// The register file sits on the slave modport; the core (or a testbench) drives the master modport.
interface z16_register_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              i_rd_en;
    logic [ADDR_W-1:0] i_rd_addr_a;
    logic [ADDR_W-1:0] i_rd_addr_b;
    logic [DATA_W-1:0] o_rd_data_a;
    logic [DATA_W-1:0] o_rd_data_b;
    logic              o_rd_valid;
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;

    modport slave (
        input  i_rd_en,
        input  i_rd_addr_a,
        input  i_rd_addr_b,
        output o_rd_data_a,
        output o_rd_data_b,
        output o_rd_valid,
        input  i_wr_en,
        input  i_wr_addr,
        input  i_wr_data
    );

    modport master (
        output i_rd_en,
        output i_rd_addr_a,
        output i_rd_addr_b,
        input  o_rd_data_a,
        input  o_rd_data_b,
        input  o_rd_valid,
        output i_wr_en,
        output i_wr_addr,
        output i_wr_data
    );
endinterface

// File: rtl/z16_register_file.sv
// Z16 16x16 register file: two registered read ports (ALU operands A/B), one write-back port.
// Define Z16_REGFILE_BYPASS_EN to forward same-cycle write data into a matching read port.
module z16_register_file #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    z16_register_file_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic [DATA_W-1:0] rd_data_a_q;
    logic [DATA_W-1:0] rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q;
    logic [DATA_W-1:0] rd_data_b_d;
    logic              rd_valid_q;
    logic              rd_valid_d;

    logic              byp_a;
    logic              byp_b;

    always_comb begin
        regs_d = regs_q;
        if (bus.i_wr_en) begin
            regs_d[bus.i_wr_addr] = bus.i_wr_data;
        end
    end

    // Each read port independently decides whether it sees the write in flight.
`ifdef Z16_REGFILE_BYPASS_EN
    assign byp_a = bus.i_wr_en && (bus.i_wr_addr == bus.i_rd_addr_a);
    assign byp_b = bus.i_wr_en && (bus.i_wr_addr == bus.i_rd_addr_b);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        rd_valid_d  = bus.i_rd_en;
        if (bus.i_rd_en) begin
            rd_data_a_d = byp_a ? bus.i_wr_data : regs_q[bus.i_rd_addr_a];
            rd_data_b_d = byp_b ? bus.i_wr_data : regs_q[bus.i_rd_addr_b];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            rd_data_a_q <= RESET_VAL;
            rd_data_b_q <= RESET_VAL;
            rd_valid_q  <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.o_rd_data_a = rd_data_a_q;
    assign bus.o_rd_data_b = rd_data_b_q;
    assign bus.o_rd_valid  = rd_valid_q;

endmodule

// File: doc/z16_register_file.md
Name: z16_register_file

Overview:
- 16-entry x 16-bit general-purpose register file for the Z16 core, directly upstream of the ALU and also its write-back sink.
- Read port A drives ALU i_data_a (source operand); read port B drives ALU i_data_b (destination operand).
- The ALU result is written back through the single write port.
- Reads are registered (1-cycle latency), so the decode -> operand -> ALU path is cleanly pipelined.

Parameters:
- DATA_W, 16, register and data width in bits.
- ADDR_W, 4, register address width; depth = 2**ADDR_W = 16.
- RESET_VAL, 16'h0000, value loaded into every register and every read-data output on reset.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rd_en  input  1  read strobe; captures both read ports this cycle.
- i_rd_addr_a  input  ADDR_W  source register index (feeds ALU i_data_a).
- i_rd_addr_b  input  ADDR_W  destination register index (feeds ALU i_data_b).
- o_rd_data_a  output  DATA_W  registered contents of register i_rd_addr_a.
- o_rd_data_b  output  DATA_W  registered contents of register i_rd_addr_b.
- o_rd_valid  output  1  high for one cycle when o_rd_data_a/b hold freshly read data.
- i_wr_en  input  1  write strobe for ALU / write-back result.
- i_wr_addr  input  ADDR_W  register index to write.
- i_wr_data  input  DATA_W  data to write.

Behaviour:
- Reset (i_rst_n low, asynchronous, no clock needed):
  - all 16 registers = RESET_VAL;
  - o_rd_data_a = o_rd_data_b = RESET_VAL;
  - o_rd_valid = 0.
  - Reset asserted mid-operation aborts any in-flight read and write.
  - First edge after deassertion behaves as a normal cycle.
- Write: on a rising edge with i_wr_en=1, reg[i_wr_addr] <= i_wr_data. All 16 indices are writable.
- Read, latency 1:
  - on a rising edge with i_rd_en=1, o_rd_data_a <= reg[i_rd_addr_a], o_rd_data_b <= reg[i_rd_addr_b], o_rd_valid <= 1.
  - With i_rd_en=0: o_rd_data_a/b hold their previous values and o_rd_valid <= 0.
- Same-address reads: i_rd_addr_a == i_rd_addr_b is legal; both outputs return the same value.
- Simultaneous read and write to the same index (i_rd_en=1, i_wr_en=1, address match): behaviour is set by the optional feature below.
- Simultaneous read and write to different indices: read returns the stored (old) contents of the read index. The write completes normally.
- o_rd_valid is a pure 1-cycle-delayed copy of i_rd_en. There is no back-pressure, and the consumer must take data in the valid cycle or rely on the hold behaviour.
- Address width is exact: no out-of-range indices exist, so there is no wrap handling.

Optional Feature:
- Macro: Z16_REGFILE_BYPASS_EN.
- Defined (write-through bypass): if i_wr_en=1, i_rd_en=1 and i_wr_addr equals a read address, that port captures i_wr_data instead of the stored value. This is evaluated per port independently, and both ports bypass if both match. The register array is still updated.
- Undefined: a same-cycle read of the written index returns the old stored value. The new value is visible from the next read onward.

Test Plan:
- Reset: write 16'h1234 to r3, pulse i_rst_n low between clocks -> immediately o_rd_data_a/b=16'h0000 and o_rd_valid=0. A read of r3 after release returns 16'h0000.
- Basic write/read: write r1=16'h00A5, then r2=16'hFF00; read a=r1, b=r2 -> next cycle o_rd_data_a=16'h00A5, o_rd_data_b=16'hFF00, o_rd_valid=1 for exactly one cycle.
- Hold: after that read, i_rd_en=0 for 3 cycles while writing r1=16'h7777 -> outputs stay 16'h00A5/16'hFF00 and o_rd_valid=0.
- Same-cycle hazard: r5=16'h0001 stored; in one cycle write r5=16'hBEEF and read a=r5, b=r5 -> with Z16_REGFILE_BYPASS_EN both outputs = 16'hBEEF; without it, both = 16'h0001. A following read returns 16'hBEEF in both builds.
- Full sweep: write reg[i] = 16'h1000+i for i=0..15, then read pairs (i, 15-i) -> every output matches and no alias across the wrap from index 15 to 0.
- Back-to-back: i_rd_en held high for 4 cycles with changing addresses -> o_rd_valid high 4 consecutive cycles, each output matching the address from the previous cycle.
